// File: rtl/fir_out_collector.sv
// Receive-side collector for FIR output pushes: buffers {I,Q} pairs and replays them as I-then-Q words.
// Optional saturating drop counter on port ovf_count when FIR_OUT_OVF_COUNT_EN is defined.
module fir_out_collector #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       PushIn,
    input  logic [W-1:0]               FI,
    input  logic [W-1:0]               FQ,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic                       out_iq,
    output logic [$clog2(DEPTH):0]     count,
`ifdef FIR_OUT_OVF_COUNT_EN
    output logic [7:0]                 ovf_count,
`endif
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_I = 2'd1,
        SEND_Q = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    hold_q, hold_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_iq_q, out_iq_d;
    logic            out_valid_q, out_valid_d;
    logic            overflow_q, overflow_d;
`ifdef FIR_OUT_OVF_COUNT_EN
    logic [7:0]      ovf_count_q, ovf_count_d;
`endif

    logic [2*W-1:0]  mem_q [DEPTH];
    logic [2*W-1:0]  head;
    logic            full;
    logic            not_empty;
    logic            do_write;
    logic            drop;
    logic            accept;
    logic            pop;

    // Full and empty are judged on the pre-edge occupancy, so a pop never frees room for a same-edge push.
    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);
    assign do_write  = PushIn && !full;
    assign drop      = PushIn && full;
    assign accept    = out_valid_q && out_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_iq_d    = out_iq_q;
        out_valid_d = out_valid_q;
        hold_d      = hold_q;
        pop         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (not_empty) begin
                    pop         = 1'b1;
                    out_data_d  = head[2*W-1:W];
                    out_iq_d    = 1'b0;
                    out_valid_d = 1'b1;
                    hold_d      = head[W-1:0];
                    state_d     = SEND_I;
                end
            end
            SEND_I: begin
                if (accept) begin
                    out_data_d = hold_q;
                    out_iq_d   = 1'b1;
                    state_d    = SEND_Q;
                end
            end
            SEND_Q: begin
                if (accept) begin
                    if (not_empty) begin
                        pop        = 1'b1;
                        out_data_d = head[2*W-1:W];
                        out_iq_d   = 1'b0;
                        hold_d     = head[W-1:0];
                        state_d    = SEND_I;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop      ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_write && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !do_write) begin
            count_d = count_q - CW'(1);
        end

        // A drop on the same edge as a clear wins, leaving the flag set.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

`ifdef FIR_OUT_OVF_COUNT_EN
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (clr_ovf) begin
            ovf_count_d = drop ? 8'd1 : 8'd0;
        end else if (drop && ovf_count_q != 8'hFF) begin
            ovf_count_d = ovf_count_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_iq_q    <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_iq_q    <= out_iq_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef FIR_OUT_OVF_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end
    assign ovf_count = ovf_count_q;
`endif

    // NOTE: FIFO storage is deliberately not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= {FI, FQ};
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_iq    = out_iq_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_out_collector.sv
// Directed self-checking bench for fir_out_collector (DEPTH=8, W=32).
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_fir_out_collector;

    logic        clk;
    logic        reset;
    logic        PushIn;
    logic [31:0] FI;
    logic [31:0] FQ;
    logic        out_ready;
    logic        clr_ovf;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_iq;
    logic [3:0]  count;
    logic        overflow;
`ifdef FIR_OUT_OVF_COUNT_EN
    logic [7:0]  ovf_count;
`endif

    int checks;
    int failures;

    fir_out_collector #(.DEPTH(8), .W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .PushIn    (PushIn),
        .FI        (FI),
        .FQ        (FQ),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_iq    (out_iq),
        .count     (count),
`ifdef FIR_OUT_OVF_COUNT_EN
        .ovf_count (ovf_count),
`endif
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; PushIn = 1'b0; FI = '0; FQ = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_iq !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%h iq=%b count=%0d ovf=%b, want all zero",
                     out_valid, out_data, out_iq, count, overflow);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_push(input logic [31:0] i_w, input logic [31:0] q_w, input string tag);
        out_ready = 1'b1;
        PushIn = 1'b1; FI = i_w; FQ = q_w;
        tick();
        PushIn = 1'b0;
        checks++;
        if (count !== 4'd1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_after_push: count=%0d valid=%b, want count=1 valid=0", tag, count, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== i_w || out_iq !== 1'b0 || count !== 4'd0) begin
            failures++;
            $display("FAIL %s_i_word: valid=%b data=%h iq=%b count=%0d, want 1 %h 0 0",
                     tag, out_valid, out_data, out_iq, count, i_w);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== q_w || out_iq !== 1'b1) begin
            failures++;
            $display("FAIL %s_q_word: valid=%b data=%h iq=%b, want 1 %h 1", tag, out_valid, out_data, out_iq, q_w);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            failures++;
            $display("FAIL %s_done: valid=%b count=%0d, want 0 0", tag, out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        int nwords;
        int first_cyc;
        int last_cyc;
        int peak;
        logic [31:0] exp_w;
        out_ready = 1'b1;
        nwords = 0; first_cyc = -1; last_cyc = -1; peak = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc < 4) begin
                PushIn = 1'b1; FI = 32'h1000_0000 + cyc; FQ = 32'hA000_0000 + cyc;
            end else begin
                PushIn = 1'b0;
            end
            tick();
            if (int'(count) > peak) peak = int'(count);
            if (out_valid) begin
                exp_w = (nwords % 2 == 0) ? 32'h1000_0000 + nwords / 2 : 32'hA000_0000 + nwords / 2;
                checks++;
                if (out_data !== exp_w || out_iq !== nwords[0]) begin
                    failures++;
                    $display("FAIL b2b_word%0d: data=%h iq=%b, want %h %b", nwords, out_data, out_iq, exp_w, nwords[0]);
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nwords++;
            end
        end
        PushIn = 1'b0;
        checks++;
        if (nwords != 8) begin
            failures++;
            $display("FAIL b2b_word_count: got %0d words, want 8", nwords);
        end
        checks++;
        if (last_cyc - first_cyc + 1 != 8) begin
            failures++;
            $display("FAIL b2b_no_bubble: span=%0d cycles, want 8", last_cyc - first_cyc + 1);
        end
        checks++;
        if (peak > 3) begin
            failures++;
            $display("FAIL b2b_peak_count: peak=%0d, want <=3", peak);
        end
    endtask

    task automatic test_backpressure();
        int nwords;
        logic [31:0] exp_w;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            PushIn = 1'b1; FI = 32'h2000_0000 + k; FQ = 32'hB000_0000 + k;
            tick();
        end
        PushIn = 1'b0;
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_full: count=%0d ovf=%b, want 8 1", count, overflow);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h2000_0000 || out_iq !== 1'b0) begin
            failures++;
            $display("FAIL bp_stage: valid=%b data=%h iq=%b, want 1 20000000 0", out_valid, out_data, out_iq);
        end
`ifdef FIR_OUT_OVF_COUNT_EN
        checks++;
        if (ovf_count !== 8'd1) begin
            failures++;
            $display("FAIL bp_ovf_count: got %0d, want 1", ovf_count);
        end
`endif
        out_ready = 1'b1;
        nwords = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid) begin
                exp_w = (nwords % 2 == 0) ? 32'h2000_0000 + nwords / 2 : 32'hB000_0000 + nwords / 2;
                checks++;
                if (out_data !== exp_w || out_iq !== nwords[0]) begin
                    failures++;
                    $display("FAIL bp_word%0d: data=%h iq=%b, want %h %b", nwords, out_data, out_iq, exp_w, nwords[0]);
                end
                nwords++;
            end
            tick();
        end
        checks++;
        if (nwords != 18 || out_valid !== 1'b0 || count !== 4'd0) begin
            failures++;
            $display("FAIL bp_drain: words=%0d valid=%b count=%0d, want 18 0 0", nwords, out_valid, count);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL bp_clr_ovf: ovf=%b, want 0", overflow);
        end
    endtask

    task automatic test_stall_stability();
        int nacc;
        logic prev_stall;
        logic [31:0] prev_data;
        logic prev_iq;
        logic [31:0] exp_w;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            PushIn = 1'b1; FI = 32'h3000_0000 + k; FQ = 32'hC000_0000 + k;
            tick();
        end
        PushIn = 1'b0;
        nacc = 0; prev_stall = 1'b0; prev_data = '0; prev_iq = 1'b0;
        for (int cyc = 0; cyc < 200 && nacc < 6; cyc++) begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_iq !== prev_iq) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%b data=%h iq=%b, want 1 %h %b",
                             out_valid, out_data, out_iq, prev_data, prev_iq);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                exp_w = (nacc % 2 == 0) ? 32'h3000_0000 + nacc / 2 : 32'hC000_0000 + nacc / 2;
                checks++;
                if (out_data !== exp_w || out_iq !== nacc[0]) begin
                    failures++;
                    $display("FAIL stall_word%0d: data=%h iq=%b, want %h %b", nacc, out_data, out_iq, exp_w, nacc[0]);
                end
                nacc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_iq    = out_iq;
            tick();
        end
        checks++;
        if (nacc != 6 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_complete: accepted=%0d valid=%b, want 6 0", nacc, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_full_edges();
        int cyc;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            PushIn = 1'b1; FI = 32'h4000_0000 + k; FQ = 32'hD000_0000 + k;
            tick();
        end
        PushIn = 1'b0;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0 || count !== 4'd8) begin
            failures++;
            $display("FAIL full_setup: ovf=%b count=%0d, want 0 8", overflow, count);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_iq !== 1'b1 || count !== 4'd8) begin
            failures++;
            $display("FAIL full_send_q: iq=%b count=%0d, want 1 8", out_iq, count);
        end
        PushIn = 1'b1; FI = 32'hDEAD_0000; FQ = 32'hDEAD_0001;
        tick();
        PushIn = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== 4'd7 || overflow !== 1'b1 || out_data !== 32'h4000_0001 || out_iq !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop: count=%0d ovf=%b data=%h iq=%b, want 7 1 40000001 0",
                     count, overflow, out_data, out_iq);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        PushIn = 1'b1; FI = 32'h4000_000A; FQ = 32'hD000_000A;
        tick();
        checks++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_refill: count=%0d ovf=%b, want 8 0", count, overflow);
        end
        clr_ovf = 1'b1;
        tick();
        PushIn = 1'b0; clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            failures++;
            $display("FAIL drop_vs_clr: ovf=%b count=%0d, want 1 8", overflow, count);
        end
`ifdef FIR_OUT_OVF_COUNT_EN
        checks++;
        if (ovf_count !== 8'd1) begin
            failures++;
            $display("FAIL drop_vs_clr_count: got %0d, want 1", ovf_count);
        end
`endif
        out_ready = 1'b1;
        cyc = 0;
        while ((out_valid || count != 4'd0) && cyc < 60) begin
            tick();
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            failures++;
            $display("FAIL full_drain_timeout: valid=%b count=%0d after %0d cycles", out_valid, count, cyc);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        out_ready = 1'b0;
        PushIn = 1'b1; FI = 32'h5000_0000; FQ = 32'hE000_0000;
        tick();
        FI = 32'h5000_0001; FQ = 32'hE000_0001;
        tick();
        PushIn = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        PushIn = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_iq !== 1'b1 || out_data !== 32'hE000_0000 || count !== 4'd1) begin
            failures++;
            $display("FAIL rst_setup: valid=%b iq=%b data=%h count=%0d, want 1 1 e0000000 1",
                     out_valid, out_iq, out_data, count);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || out_iq !== 1'b0 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_async: valid=%b count=%0d ovf=%b iq=%b data=%h, want all zero",
                     out_valid, count, overflow, out_iq, out_data);
        end
        #1;
        reset = 1'b1;
        tick();
        test_single_push(32'h0600_0000, 32'hF600_0000, "post_reset");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_push(32'h0100_0000, 32'hFF00_0000, "single");
        test_back_to_back();
        test_backpressure();
        test_stall_stability();
        test_full_edges();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
